// File: rtl/dccm_banked_mem_if.sv
// dccm_banked_mem_if: request/response bundle of the banked DCCM.
// The master side (core/LSU) drives requests; the slave side is the memory.
interface dccm_banked_mem_if #(
  parameter int DATA_W = 39,
  parameter int ADDR_W = 16
);
  logic              lsu_freeze;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr_lo;
  logic [ADDR_W-1:0] rd_addr_hi;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data_lo;
  logic [DATA_W-1:0] rd_data_hi;
  logic              rd_conflict;
  logic [2:0]        wbuf_count;
  logic [15:0]       bank_conflict_cnt;

  modport master (
    output lsu_freeze, wr_valid, wr_addr, wr_data, rd_en, rd_addr_lo, rd_addr_hi,
    input  wr_ready, rd_ready, rd_valid, rd_data_lo, rd_data_hi, rd_conflict,
           wbuf_count, bank_conflict_cnt
  );

  modport slave (
    input  lsu_freeze, wr_valid, wr_addr, wr_data, rd_en, rd_addr_lo, rd_addr_hi,
    output wr_ready, rd_ready, rd_valid, rd_data_lo, rd_data_hi, rd_conflict,
           wbuf_count, bank_conflict_cnt
  );
endinterface

// File: rtl/dccm_banked_mem.sv
// dccm_banked_mem: banked, single-ported-per-bank DCCM with dual read ports,
// an in-order write buffer, read-priority bank arbitration and a starvation
// bound that forces the buffer head to drain.
// Optional feature macro: RV_DCCM_WBUF_FWD_EN -- when defined, reads hitting a
// buffered write are forwarded from the buffer; otherwise such reads stall
// until the matching entries have drained.
module dccm_banked_mem #(
  parameter int DATA_W       = 39,
  parameter int ADDR_W       = 16,
  parameter int NUM_BANKS    = 4,
  parameter int WBUF_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic         clk,
  input logic         rst_l,
  dccm_banked_mem_if.slave bus
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int WORD_W = ADDR_W - 2;
  localparam int ROW_W  = WORD_W - BANK_W;
  localparam int ROWS   = 1 << ROW_W;

  // Storage array: NUM_BANKS independent single-ported banks, never reset.
  logic [DATA_W-1:0] mem [NUM_BANKS][ROWS];

  // Write buffer kept as a shift register, entry 0 is always the oldest.
  logic [WORD_W-1:0] entWord_q [WBUF_DEPTH];
  logic [WORD_W-1:0] entWord_d [WBUF_DEPTH];
  logic [DATA_W-1:0] entData_q [WBUF_DEPTH];
  logic [DATA_W-1:0] entData_d [WBUF_DEPTH];
  logic [2:0]        count_q, count_d;
  logic [7:0]        blkCnt_q, blkCnt_d;
  logic [15:0]       confCnt_q, confCnt_d;

  logic              rdValid_q, rdValid_d;
  logic              rdConflict_q, rdConflict_d;
  logic [DATA_W-1:0] rdDataLo_q, rdDataLo_d;
  logic [DATA_W-1:0] rdDataHi_q, rdDataHi_d;

  logic [WORD_W-1:0] loWord, hiWord, wrWord, headWord;
  logic [BANK_W-1:0] loBank, hiBank, headBank;
  logic [ROW_W-1:0]  loRow, hiRow, headRow;

  logic [WBUF_DEPTH-1:0] entValid;
  logic loHit, hiHit;
  logic fwdStall, forceDrain, rdReady, rdAccept, wrReady, wrAccept;
  logic headValid, drain, rdConflict;
  logic [DATA_W-1:0] rdLoData, rdHiData;
  logic [2:0] wrIdx;

  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.wr_addr[1:0], bus.rd_addr_lo[1:0], bus.rd_addr_hi[1:0]};

  assign loWord   = bus.rd_addr_lo[ADDR_W-1:2];
  assign hiWord   = bus.rd_addr_hi[ADDR_W-1:2];
  assign wrWord   = bus.wr_addr[ADDR_W-1:2];
  assign headWord = entWord_q[0];
  assign loBank   = loWord[BANK_W-1:0];
  assign hiBank   = hiWord[BANK_W-1:0];
  assign headBank = headWord[BANK_W-1:0];
  assign loRow    = loWord[WORD_W-1:BANK_W];
  assign hiRow    = hiWord[WORD_W-1:BANK_W];
  assign headRow  = headWord[WORD_W-1:BANK_W];

  // Occupied slots and read-address hits against entries present at cycle start.
  always_comb begin
    entValid = '0;
    loHit    = 1'b0;
    hiHit    = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      entValid[i] = (3'(i) < count_q);
      if (entValid[i] && (entWord_q[i] == loWord)) loHit = 1'b1;
      if (entValid[i] && (entWord_q[i] == hiWord)) hiHit = 1'b1;
    end
  end

  assign rdConflict = (loBank == hiBank) && (loRow != hiRow);

`ifdef RV_DCCM_WBUF_FWD_EN
  logic [DATA_W-1:0] loFwdData, hiFwdData;

  // Youngest matching entry wins, so later slots override earlier ones.
  always_comb begin
    loFwdData = '0;
    hiFwdData = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (entValid[i] && (entWord_q[i] == loWord)) loFwdData = entData_q[i];
      if (entValid[i] && (entWord_q[i] == hiWord)) hiFwdData = entData_q[i];
    end
  end

  assign fwdStall = 1'b0;
  assign rdLoData = loHit ? loFwdData : mem[loBank][loRow];
  assign rdHiData = rdConflict ? '0 : (hiHit ? hiFwdData : mem[hiBank][hiRow]);
`else
  assign fwdStall = loHit | hiHit;
  assign rdLoData = mem[loBank][loRow];
  assign rdHiData = rdConflict ? '0 : mem[hiBank][hiRow];
`endif

  assign forceDrain = (blkCnt_q >= 8'(STARVE_LIMIT));
  assign rdReady    = ~forceDrain & ~bus.lsu_freeze & ~fwdStall;
  assign rdAccept   = bus.rd_en & rdReady;
  assign wrReady    = (count_q != 3'(WBUF_DEPTH));
  assign wrAccept   = bus.wr_valid & wrReady;
  assign headValid  = (count_q != 3'd0);
  assign drain      = headValid & ~(rdAccept & ((headBank == loBank) | (headBank == hiBank)));
  assign wrIdx      = drain ? (count_q - 3'd1) : count_q;

  // Buffer next state: shift out the head on drain, append at the tail on accept.
  always_comb begin
    entWord_d = entWord_q;
    entData_d = entData_q;
    count_d   = count_q;
    if (drain) begin
      for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
        entWord_d[i] = entWord_q[i+1];
        entData_d[i] = entData_q[i+1];
      end
      count_d = count_q - 3'd1;
    end
    if (wrAccept) begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        if (3'(i) == wrIdx) begin
          entWord_d[i] = wrWord;
          entData_d[i] = bus.wr_data;
        end
      end
      count_d = count_d + 3'd1;
    end
  end

  // Starvation and statistics counters for a head entry that loses arbitration.
  always_comb begin
    blkCnt_d  = blkCnt_q;
    confCnt_d = confCnt_q;
    if (drain) begin
      blkCnt_d = 8'd0;
    end else if (headValid) begin
      blkCnt_d = blkCnt_q + 8'd1;
      if (confCnt_q != 16'hFFFF) confCnt_d = confCnt_q + 16'd1;
    end
  end

  // Read response: capture on accept, hold while frozen, otherwise go idle.
  always_comb begin
    rdValid_d    = rdValid_q;
    rdConflict_d = rdConflict_q;
    rdDataLo_d   = rdDataLo_q;
    rdDataHi_d   = rdDataHi_q;
    if (rdAccept) begin
      rdValid_d    = 1'b1;
      rdConflict_d = rdConflict;
      rdDataLo_d   = rdLoData;
      rdDataHi_d   = rdHiData;
    end else if (!bus.lsu_freeze) begin
      rdValid_d    = 1'b0;
      rdConflict_d = 1'b0;
    end
  end

  // Bank write port: the drained head entry lands in its bank.
  always_ff @(posedge clk) begin
    if (drain) mem[headBank][headRow] <= entData_q[0];
  end

  // State registers; reset discards any buffered writes.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        entWord_q[i] <= '0;
        entData_q[i] <= '0;
      end
      count_q      <= 3'd0;
      blkCnt_q     <= 8'd0;
      confCnt_q    <= 16'd0;
      rdValid_q    <= 1'b0;
      rdConflict_q <= 1'b0;
      rdDataLo_q   <= '0;
      rdDataHi_q   <= '0;
    end else begin
      entWord_q    <= entWord_d;
      entData_q    <= entData_d;
      count_q      <= count_d;
      blkCnt_q     <= blkCnt_d;
      confCnt_q    <= confCnt_d;
      rdValid_q    <= rdValid_d;
      rdConflict_q <= rdConflict_d;
      rdDataLo_q   <= rdDataLo_d;
      rdDataHi_q   <= rdDataHi_d;
    end
  end

  assign bus.wr_ready          = wrReady;
  assign bus.rd_ready          = rdReady;
  assign bus.rd_valid          = rdValid_q;
  assign bus.rd_conflict       = rdConflict_q;
  assign bus.rd_data_lo        = rdDataLo_q;
  assign bus.rd_data_hi        = rdDataHi_q;
  assign bus.wbuf_count        = count_q;
  assign bus.bank_conflict_cnt = confCnt_q;

endmodule

// File: tb/tb_dccm_banked_mem.sv
// tb_dccm_banked_mem: randomized and directed stimulus for dccm_banked_mem,
// checked every cycle against a queue/associative-array model of the memory.
module tb_dccm_banked_mem;

  localparam int DATA_W       = 39;
  localparam int ADDR_W       = 16;
  localparam int NUM_BANKS    = 4;
  localparam int WBUF_DEPTH   = 2;
  localparam int STARVE_LIMIT = 8;
  localparam int WORD_W       = ADDR_W - 2;
`ifdef RV_DCCM_WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dccm_banked_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dccm_banked_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS),
    .WBUF_DEPTH(WBUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus)
  );

  typedef struct {
    logic [WORD_W-1:0] w;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              wq[$];
  logic [DATA_W-1:0] mm[int];
  int                blk, ccnt;
  bit                mValid, mConf, mLoKnown, mHiKnown;
  logic [DATA_W-1:0] mLo, mHi;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic re, input logic [ADDR_W-1:0] alo, input logic [ADDR_W-1:0] ahi,
                               input logic frz);
    bus.wr_valid   = wv;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.rd_en      = re;
    bus.rd_addr_lo = alo;
    bus.rd_addr_hi = ahi;
    bus.lsu_freeze = frz;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic resetDut();
    idle();
    rst_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  // Newest buffered value (when forwarding exists), else committed memory.
  function automatic void lookupWord(input logic [WORD_W-1:0] w, output logic [DATA_W-1:0] d, output bit known);
    d     = '0;
    known = 1'b0;
    if (FWD) begin
      for (int i = wq.size() - 1; i >= 0; i--) begin
        if (wq[i].w == w) begin
          d     = wq[i].d;
          known = 1'b1;
          return;
        end
      end
    end
    if (mm.exists(int'(w))) begin
      d     = mm[int'(w)];
      known = 1'b1;
    end
  endfunction

  // Model + compare: check registered outputs, then advance the model by the
  // cycle whose inputs are currently applied.
  always @(negedge clk) begin : modelProc
    int n, loW, hiW, loBank, hiBank, loRow, hiRow, headBank;
    bit stall, expRdReady, rdAcc, headHit;
    if (!rst_l) begin
      wq.delete();
      blk = 0; ccnt = 0;
      mValid = 0; mConf = 0; mLo = '0; mHi = '0; mLoKnown = 1; mHiKnown = 1;
      checkOutput("reset_wbuf_count", 64'(bus.wbuf_count), 64'd0);
      checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
      checkOutput("reset_wr_ready", 64'(bus.wr_ready), 64'd1);
      checkOutput("reset_conflict_cnt", 64'(bus.bank_conflict_cnt), 64'd0);
    end else begin
      n   = wq.size();
      loW = int'(bus.rd_addr_lo[ADDR_W-1:2]);
      hiW = int'(bus.rd_addr_hi[ADDR_W-1:2]);
      stall = 1'b0;
      if (!FWD) foreach (wq[i]) if (int'(wq[i].w) == loW || int'(wq[i].w) == hiW) stall = 1'b1;
      expRdReady = (blk < STARVE_LIMIT) && !bus.lsu_freeze && !stall;

      checkOutput("wbuf_count", 64'(bus.wbuf_count), 64'(n));
      checkOutput("wr_ready", 64'(bus.wr_ready), 64'(n < WBUF_DEPTH));
      checkOutput("rd_ready", 64'(bus.rd_ready), 64'(expRdReady));
      checkOutput("bank_conflict_cnt", 64'(bus.bank_conflict_cnt), 64'(ccnt));
      checkOutput("rd_valid", 64'(bus.rd_valid), 64'(mValid));
      if (mValid) begin
        checkOutput("rd_conflict", 64'(bus.rd_conflict), 64'(mConf));
        if (mLoKnown) checkOutput("rd_data_lo", 64'(bus.rd_data_lo), 64'(mLo));
        if (mHiKnown) checkOutput("rd_data_hi", 64'(bus.rd_data_hi), 64'(mHi));
      end

      rdAcc  = bus.rd_en && expRdReady;
      loBank = loW % NUM_BANKS; loRow = loW / NUM_BANKS;
      hiBank = hiW % NUM_BANKS; hiRow = hiW / NUM_BANKS;
      if (rdAcc) begin
        mValid = 1'b1;
        mConf  = (loBank == hiBank) && (loRow != hiRow);
        lookupWord(WORD_W'(loW), mLo, mLoKnown);
        if (mConf) begin
          mHi = '0; mHiKnown = 1'b1;
        end else begin
          lookupWord(WORD_W'(hiW), mHi, mHiKnown);
        end
      end else if (!bus.lsu_freeze) begin
        mValid = 1'b0;
        mConf  = 1'b0;
      end

      if (n > 0) begin
        headBank = int'(wq[0].w) % NUM_BANKS;
        headHit  = rdAcc && (headBank == loBank || headBank == hiBank);
        if (!headHit) begin
          mm[int'(wq[0].w)] = wq[0].d;
          void'(wq.pop_front());
          blk = 0;
        end else begin
          blk++;
          if (ccnt < 65535) ccnt++;
        end
      end

      if (bus.wr_valid && n < WBUF_DEPTH)
        wq.push_back('{w: bus.wr_addr[ADDR_W-1:2], d: bus.wr_data});
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [DATA_W-1:0] valB, valV1, valV2, dRand;
    logic [ADDR_W-1:0] aW, aLo, aHi;
    int cycles;
    idle();
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Populate a small pool of words spanning every bank and four rows.
    for (int w = 0; w < 16; w++) begin
      dRand = DATA_W'({$urandom, $urandom});
      applyStimulus(1'b1, ADDR_W'(w * 4), dRand, 1'b0, '0, '0, 1'b0);
      stepCycle();
    end
    idle(); stepCycle(); stepCycle();

    $display("[TB] write then read after drain");
    resetDut();
    applyStimulus(1'b1, 16'h0100, 39'h12345678, 1'b0, '0, '0, 1'b0);
    stepCycle();
    idle(); stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0100, 16'h0104, 1'b0);
    #1 checkOutput("t1_rd_ready", 64'(bus.rd_ready), 64'd1);
    stepCycle();
    checkOutput("t1_rd_valid", 64'(bus.rd_valid), 64'd1);
    checkOutput("t1_rd_data_lo", 64'(bus.rd_data_lo), 64'h12345678);

    $display("[TB] starvation and forced drain");
    resetDut();
    applyStimulus(1'b1, 16'h0100, 39'h0AAAA, 1'b1, 16'h0000, 16'h0000, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h0110, 39'h0BBBB, 1'b1, 16'h0000, 16'h0000, 1'b0);
    stepCycle();
    checkOutput("t2_count_full", 64'(bus.wbuf_count), 64'd2);
    checkOutput("t2_wr_ready_full", 64'(bus.wr_ready), 64'd0);
    checkOutput("t2_cnt_first", 64'(bus.bank_conflict_cnt), 64'd1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 16'h0120, 39'h0CCCC, 1'b1, 16'h0000, 16'h0000, 1'b0);
      stepCycle();
    end
    checkOutput("t2_cnt_eight", 64'(bus.bank_conflict_cnt), 64'd8);
    checkOutput("t2_count_still_full", 64'(bus.wbuf_count), 64'd2);
    #1 checkOutput("t2_forced_rd_ready", 64'(bus.rd_ready), 64'd0);
    stepCycle();
    checkOutput("t2_count_after_force", 64'(bus.wbuf_count), 64'd1);
    checkOutput("t2_cnt_after_force", 64'(bus.bank_conflict_cnt), 64'd8);
    idle();
    #1 checkOutput("t2_rd_ready_restored", 64'(bus.rd_ready), 64'd1);
    stepCycle();
    checkOutput("t2_count_empty", 64'(bus.wbuf_count), 64'd0);

    $display("[TB] same bank different row");
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0000, 16'h0010, 1'b0);
    stepCycle();
    checkOutput("t3_rd_valid", 64'(bus.rd_valid), 64'd1);
    checkOutput("t3_rd_conflict", 64'(bus.rd_conflict), 64'd1);
    checkOutput("t3_rd_data_hi", 64'(bus.rd_data_hi), 64'd0);

    $display("[TB] youngest write wins");
    valB = 39'h7B0B0B0B0B;
    applyStimulus(1'b1, 16'h0200, 39'h1A0A0A0A0A, 1'b0, '0, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h0200, valB, 1'b0, '0, '0, 1'b0);
    stepCycle();
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 16'h0200, 16'h0204, 1'b0);
      stepCycle();
      cycles++;
      if (bus.rd_valid) break;
    end
    checkOutput("t4_rd_valid", 64'(bus.rd_valid), 64'd1);
    checkOutput("t4_rd_data_lo", 64'(bus.rd_data_lo), 64'(valB));
    checkOutput("t4_latency", 64'(cycles), FWD ? 64'd1 : 64'd2);
    idle(); stepCycle(); stepCycle();

    $display("[TB] freeze holds read data");
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0200, 16'h0204, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h0300, 39'h0123, 1'b1, 16'h0000, 16'h0004, 1'b1);
    #1 checkOutput("t5_rd_ready_frozen", 64'(bus.rd_ready), 64'd0);
    stepCycle();
    applyStimulus(1'b1, 16'h0304, 39'h0456, 1'b1, 16'h0000, 16'h0004, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    stepCycle(); stepCycle();
    checkOutput("t5_rd_valid_held", 64'(bus.rd_valid), 64'd1);
    checkOutput("t5_rd_data_lo_held", 64'(bus.rd_data_lo), 64'(valB));
    checkOutput("t5_count_drained", 64'(bus.wbuf_count), 64'd0);
    idle(); stepCycle();

    $display("[TB] reset discards buffered writes");
    valV1 = 39'h5A5A5A5A5;
    valV2 = 39'h3C3C3C3C3;
    applyStimulus(1'b1, 16'h0400, valV1, 1'b0, '0, '0, 1'b0);
    stepCycle();
    idle(); stepCycle(); stepCycle();
    applyStimulus(1'b1, 16'h0400, valV2, 1'b1, 16'h0000, 16'h0000, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h0410, valV2, 1'b1, 16'h0000, 16'h0000, 1'b0);
    stepCycle();
    checkOutput("t6_count_before", 64'(bus.wbuf_count), 64'd2);
    idle();
    rst_l = 1'b0;
    #1;
    checkOutput("t6_count_reset", 64'(bus.wbuf_count), 64'd0);
    checkOutput("t6_rd_valid_reset", 64'(bus.rd_valid), 64'd0);
    checkOutput("t6_rd_data_lo_reset", 64'(bus.rd_data_lo), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0400, 16'h0400, 1'b0);
    stepCycle();
    checkOutput("t6_rd_valid_after", 64'(bus.rd_valid), 64'd1);
    checkOutput("t6_old_data", 64'(bus.rd_data_lo), 64'(valV1));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      aW    = ADDR_W'($urandom_range(0, 15) * 4);
      aLo   = ADDR_W'($urandom_range(0, 15) * 4);
      aHi   = ADDR_W'($urandom_range(0, 15) * 4);
      dRand = DATA_W'({$urandom, $urandom});
      applyStimulus(($urandom_range(0, 99) < 50), aW, dRand,
                    ($urandom_range(0, 99) < 60), aLo, aHi,
                    ($urandom_range(0, 99) < 10));
      stepCycle();
    end
    idle();
    repeat (5) stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
